// File: rtl/rv32_dbus_pkg.sv
// Shared types and helpers for the dext_* data-bus responder and its RAM.
package rv32_dbus_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    // Responder FSM: idle, counting wait states, presenting the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dbus_rsp_state_t;

    // Expands a byte-enable vector into a full-width lane mask.
    function automatic logic [XLEN-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [XLEN-1:0] mask;
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rv32_mod_be_ram.sv
// Synchronous word RAM with per-byte write enables and a registered read port.
// Write and read use separate addresses so a back-to-back read can be issued in
// the same cycle that the previous write commits; when they hit the same word the
// read returns the freshly merged data (write-first).
module rv32_mod_be_ram
   import rv32_dbus_pkg::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter string INIT_FILE   = "",
   localparam int   AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [BE_W-1:0] wbe_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic            re_i,
   input  logic [AW-1:0]   raddr_i,
   output logic [XLEN-1:0] rdata_o
);

   logic [XLEN-1:0] mem_q [DEPTH_WORDS];
   logic [XLEN-1:0] rdata_q;
   logic [XLEN-1:0] wmask;
   logic [XLEN-1:0] merged;

   // Word as it will look after this cycle's write, used for the write-first bypass.
   always_comb begin
      wmask  = be_mask(wbe_i);
      merged = (mem_q[waddr_i] & ~wmask) | (wdata_i & wmask);
   end

   // Byte-lane writes and the registered read port; contents are never cleared by reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (we_i && wbe_i[i]) begin
            mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= (we_i && (waddr_i == raddr_i)) ? merged : mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32_mod_data_ram_responder.sv
// Responder end of the LSU dext_* bus: fixed wait-state latency, range/byte-enable
// error detection, word reads and byte-enabled writes into an on-chip RAM.
module rv32_mod_data_ram_responder
    import rv32_dbus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dext_req,
    input  logic            dext_wr,
    input  logic [BE_W-1:0] dext_be,
    input  logic [XLEN-1:0] dext_addr,
    input  logic [XLEN-1:0] dext_do,
    output logic            dext_ack,
    output logic            dext_err,
    output logic [XLEN-1:0] dext_di,
    output logic            busy
);

    localparam int            AW       = $clog2(DEPTH_WORDS);
    // One bit wider than the bus so a window ending at 4 GiB does not wrap.
    localparam logic [XLEN:0] SPAN     = (XLEN+1)'(DEPTH_WORDS) << 2;
    localparam logic [XLEN:0] LIMIT    = {1'b0, BASE_ADDR} + SPAN;
    // BASE_ADDR is span-aligned, so this is normally zero; kept for clarity of intent.
    localparam logic [AW-1:0] BASE_IDX = BASE_ADDR[AW+1:2];
    localparam logic [3:0]    CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dbus_rsp_state_t state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [BE_W-1:0] be_q, be_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            err_q, err_d;
    logic            ack_q, ack_d;
    logic            rsperr_q, rsperr_d;
    logic            rdack_q, rdack_d;

    logic            accept;
    logic            req_err;
    logic [AW-1:0]   req_idx;
    logic            ram_we;
    logic            ram_re;
    logic [AW-1:0]   ram_raddr;
    logic [XLEN-1:0] ram_rdata;

    // Classify the incoming request: out of window or no lanes enabled is an error.
    always_comb begin
        req_err = ({1'b0, dext_addr} < {1'b0, BASE_ADDR}) ||
                  ({1'b0, dext_addr} >= LIMIT) ||
                  (dext_be == '0);
        req_idx = dext_addr[AW+1:2] - BASE_IDX;
    end

    // Next-state, request latch and the response flags registered on entry to RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        be_d     = be_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        ack_d    = 1'b0;
        rsperr_d = 1'b0;
        rdack_d  = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE, RESP: begin
                if (dext_req) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            wr_d    = dext_wr;
            be_d    = dext_be;
            idx_d   = req_idx;
            wdata_d = dext_do;
            err_d   = req_err;
            cnt_d   = CNT_INIT;
            state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end

        if (state_d == RESP) begin
            ack_d    = !err_d;
            rsperr_d = err_d;
            rdack_d  = !err_d && !wr_d;
        end
    end

    // RAM control: writes commit in RESP; reads are issued one cycle before RESP,
    // which with zero wait states is the request cycle itself (hence the live index).
    always_comb begin
        ram_we    = (state_q == RESP) && wr_q && !err_q;
        ram_re    = (accept && (WAIT_STATES == 0) && !dext_wr && !req_err) ||
                    ((state_q == WAIT) && (cnt_q == 4'd0) && !wr_q && !err_q);
        ram_raddr = (state_q == WAIT) ? idx_q : req_idx;
    end

    // State, latched request and output registers; reset abandons any transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            rsperr_q <= 1'b0;
            rdack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            rsperr_q <= rsperr_d;
            rdack_q  <= rdack_d;
        end
    end

    rv32_mod_be_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (idx_q),
        .wbe_i   (be_q),
        .wdata_i (wdata_q),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign dext_ack = ack_q;
    assign dext_err = rsperr_q;
    assign dext_di  = rdack_q ? ram_rdata : '0;
    assign busy     = (state_q != IDLE);

`ifdef RV32_DBUS_PROTOCOL_CHECKS
    // A request while counting wait states is a master protocol violation.
    assert property (@(posedge clk) disable iff (reset) !((state_q == WAIT) && dext_req))
        else $error("dext_req dropped while in WAIT");
`endif

endmodule

// File: tb/tb_rv32_mod_data_ram_responder.sv
// Self-checking bench: three responder instances (1, 0 and 3 wait states) checked
// against a word-array memory model, a vector table, corner sequences and random traffic.
module tb_rv32_mod_data_ram_responder;

    logic        clock = 1'b0;
    logic        rst  [3];
    logic        req  [3];
    logic        wr   [3];
    logic [3:0]  be   [3];
    logic [31:0] addr [3];
    logic [31:0] dout [3];
    logic        ack  [3];
    logic        err  [3];
    logic [31:0] di   [3];
    logic        busy [3];

    int checks = 0;
    int failures = 0;

    logic [31:0] refMem [3][1024];

    typedef struct {
        int          dev;
        bit          isWrite;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
        bit          expAck;
        bit          expErr;
        logic [31:0] expDi;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    rv32_mod_data_ram_responder #(
        .BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(1), .INIT_FILE("")
    ) dut0 (
        .clk(clock), .reset(rst[0]), .dext_req(req[0]), .dext_wr(wr[0]), .dext_be(be[0]),
        .dext_addr(addr[0]), .dext_do(dout[0]), .dext_ack(ack[0]), .dext_err(err[0]),
        .dext_di(di[0]), .busy(busy[0])
    );

    rv32_mod_data_ram_responder #(
        .BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(64), .WAIT_STATES(0), .INIT_FILE("")
    ) dut1 (
        .clk(clock), .reset(rst[1]), .dext_req(req[1]), .dext_wr(wr[1]), .dext_be(be[1]),
        .dext_addr(addr[1]), .dext_do(dout[1]), .dext_ack(ack[1]), .dext_err(err[1]),
        .dext_di(di[1]), .busy(busy[1])
    );

    rv32_mod_data_ram_responder #(
        .BASE_ADDR(32'h0000_2000), .DEPTH_WORDS(16), .WAIT_STATES(3), .INIT_FILE("")
    ) dut2 (
        .clk(clock), .reset(rst[2]), .dext_req(req[2]), .dext_wr(wr[2]), .dext_be(be[2]),
        .dext_addr(addr[2]), .dext_do(dout[2]), .dext_ack(ack[2]), .dext_err(err[2]),
        .dext_di(di[2]), .busy(busy[2])
    );

    function automatic int wsOf(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    function automatic longint baseOf(input int d);
        return (d == 2) ? 64'h2000 : 64'h0;
    endfunction

    function automatic longint depthOf(input int d);
        return (d == 0) ? 1024 : (d == 1) ? 64 : 16;
    endfunction

    // Model: an access errors when outside [base, base+4*depth) or with no lanes enabled.
    function automatic bit refErr(input int d, input logic [31:0] a, input logic [3:0] b);
        longint la;
        la = longint'(a);
        return (la < baseOf(d)) || (la >= baseOf(d) + 4 * depthOf(d)) || (b == 4'h0);
    endfunction

    function automatic int refIdx(input int d, input logic [31:0] a);
        return int'((longint'(a) - baseOf(d)) / 4);
    endfunction

    // Model: successful writes replace only the enabled bytes.
    task automatic refApply(input int d, input bit w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] dat);
        if (w && !refErr(d, a, b)) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) refMem[d][refIdx(d, a)][8*i +: 8] = dat[8*i +: 8];
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int d, input bit w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] dat);
        req[d]  = 1'b1;
        wr[d]   = w;
        be[d]   = b;
        addr[d] = a;
        dout[d] = dat;
    endtask

    task automatic checkOutput(input int d, input string name, input bit expAck,
                               input bit expErr, input logic [31:0] expDi, input bit expBusy);
        check({name, "_ack"}, {31'b0, ack[d]}, {31'b0, expAck});
        check({name, "_err"}, {31'b0, err[d]}, {31'b0, expErr});
        check({name, "_di"}, di[d], expDi);
        check({name, "_busy"}, {31'b0, busy[d]}, {31'b0, expBusy});
    endtask

    // One isolated transfer: silent for WAIT_STATES cycles, one response cycle, then idle.
    task automatic doTxn(input int d, input bit w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] dat, input bit expAck, input bit expErr,
                         input logic [31:0] expDi, input string name);
        @(negedge clock);
        applyStimulus(d, w, b, a, dat);
        for (int c = 1; c <= wsOf(d); c++) begin
            @(negedge clock);
            req[d] = 1'b0;
            check({name, "_early"}, {30'b0, ack[d], err[d]}, 32'h0);
        end
        @(negedge clock);
        req[d] = 1'b0;
        checkOutput(d, name, expAck, expErr, expDi, 1'b1);
        @(negedge clock);
        check({name, "_after"}, {29'b0, ack[d], err[d], busy[d]}, 32'h0);
        refApply(d, w, b, a, dat);
    endtask

    // Random transfer with expectations taken from the memory model.
    task automatic randomTxn(input int n);
        int          d;
        bit          w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] dat;
        bit          e;
        d   = $urandom_range(0, 2);
        w   = 1'($urandom_range(0, 1));
        b   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        dat = $urandom;
        if ($urandom_range(0, 5) == 0) begin
            a = 32'(baseOf(d) + 4 * depthOf(d) + 4 * longint'($urandom_range(0, 3)));
        end else begin
            a = 32'(baseOf(d) + 4 * longint'($urandom_range(0, 7)));
        end
        e = refErr(d, a, b);
        doTxn(d, w, b, a, dat, !e, e, (!e && !w) ? refMem[d][refIdx(d, a)] : 32'h0,
              $sformatf("rnd%0d_d%0d", n, d));
    endtask

    task automatic addVec(input int d, input bit w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] dat, input bit eAck, input bit eErr,
                          input logic [31:0] eDi);
        vec_t v;
        v.dev = d; v.isWrite = w; v.be = b; v.addr = a; v.data = dat;
        v.expAck = eAck; v.expErr = eErr; v.expDi = eDi;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] lastWrite;
        logic [31:0] val;
        bit          prevRead;
        int          ackCount;

        // dev, wr, be, addr, data, ack, err, di
        addVec(0, 1, 4'hF, 32'h10,   32'hDEADBEEF, 1, 0, 32'h0);
        addVec(0, 0, 4'hF, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF);
        addVec(0, 1, 4'h4, 32'h10,   32'h00AA0000, 1, 0, 32'h0);
        addVec(0, 0, 4'hF, 32'h10,   32'h0,        1, 0, 32'hDEAABEEF);
        addVec(0, 0, 4'hF, 32'h1000, 32'h0,        0, 1, 32'h0);
        addVec(0, 1, 4'h0, 32'h10,   32'h12345678, 0, 1, 32'h0);
        addVec(0, 0, 4'hF, 32'h10,   32'h0,        1, 0, 32'hDEAABEEF);
        addVec(0, 1, 4'hF, 32'hFFC,  32'hCAFEF00D, 1, 0, 32'h0);
        addVec(0, 0, 4'h0, 32'hFFC,  32'h0,        0, 1, 32'h0);
        addVec(0, 0, 4'hF, 32'hFFC,  32'h0,        1, 0, 32'hCAFEF00D);
        addVec(0, 1, 4'h9, 32'h10,   32'h11000022, 1, 0, 32'h0);
        addVec(0, 0, 4'h3, 32'h10,   32'h0,        1, 0, 32'h11AABE22);
        addVec(2, 1, 4'hF, 32'h1FFC, 32'h0,        0, 1, 32'h0);
        addVec(2, 1, 4'hF, 32'h2040, 32'h0,        0, 1, 32'h0);
        addVec(2, 1, 4'hF, 32'h203C, 32'h55AA33CC, 1, 0, 32'h0);
        addVec(2, 0, 4'hF, 32'h203C, 32'h0,        1, 0, 32'h55AA33CC);
        addVec(1, 1, 4'hF, 32'h100,  32'h0,        0, 1, 32'h0);
        addVec(1, 1, 4'hF, 32'hFC,   32'hA0B0C0D0, 1, 0, 32'h0);
        addVec(1, 1, 4'h3, 32'hFC,   32'h00001234, 1, 0, 32'h0);
        addVec(1, 0, 4'hF, 32'hFC,   32'h0,        1, 0, 32'hA0B01234);

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; be[d] = 4'h0;
            addr[d] = 32'h0; dout[d] = 32'h0;
        end
        repeat (2) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            checkOutput(d, $sformatf("reset_d%0d", d), 1'b0, 1'b0, 32'h0, 1'b0);
            rst[d] = 1'b0;
        end

        foreach (vecs[i]) begin
            doTxn(vecs[i].dev, vecs[i].isWrite, vecs[i].be, vecs[i].addr, vecs[i].data,
                  vecs[i].expAck, vecs[i].expErr, vecs[i].expDi, $sformatf("vec%0d", i));
        end

        // Zero wait states, request every cycle alternating write/read on one word.
        lastWrite = 32'h0;
        prevRead  = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clock);
            if (k > 0) begin
                check($sformatf("b2b%0d_ack", k), {30'b0, ack[1], err[1]}, 32'h2);
                check($sformatf("b2b%0d_di", k), di[1], prevRead ? lastWrite : 32'h0);
            end
            if (k < 10) begin
                prevRead = (k % 2) == 1;
                val = $urandom;
                applyStimulus(1, !prevRead, 4'hF, 32'h20, val);
                if (!prevRead) begin
                    lastWrite = val;
                    refApply(1, 1'b1, 4'hF, 32'h20, val);
                end
            end else begin
                req[1] = 1'b0;
            end
        end
        @(negedge clock);
        check("b2b_idle", {30'b0, ack[1], busy[1]}, 32'h0);

        // Reset during WAIT drops the pending write.
        doTxn(0, 1, 4'hF, 32'h30, 32'h11111111, 1, 0, 32'h0, "rstw_init");
        @(negedge clock);
        applyStimulus(0, 1'b1, 4'hF, 32'h30, 32'h22222222);
        @(negedge clock);
        req[0] = 1'b0;
        check("rstw_inwait_busy", {31'b0, busy[0]}, 32'h1);
        rst[0] = 1'b1;
        @(negedge clock);
        checkOutput(0, "rstw_held", 1'b0, 1'b0, 32'h0, 1'b0);
        rst[0] = 1'b0;
        doTxn(0, 0, 4'hF, 32'h30, 32'h0, 1, 0, 32'h11111111, "rstw_read");

        // Three wait states: a request pulsed during WAIT is ignored.
        doTxn(2, 1, 4'hF, 32'h2008, 32'h0BADCAFE, 1, 0, 32'h0, "w3_init");
        @(negedge clock);
        applyStimulus(2, 1'b0, 4'hF, 32'h2008, 32'h0);
        ackCount = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            ackCount += int'(ack[2]);
            check($sformatf("w3_c%0d_busy", c), {31'b0, busy[2]}, {31'b0, c <= 4});
            check($sformatf("w3_c%0d_resp", c), {30'b0, ack[2], err[2]},
                  (c == 4) ? 32'h2 : 32'h0);
            if (c == 4) check("w3_di", di[2], 32'h0BADCAFE);
            if (c == 1) applyStimulus(2, 1'b1, 4'hF, 32'h2008, 32'h0);
            else        req[2] = 1'b0;
        end
        check("w3_ackcount", 32'(ackCount), 32'h1);
        doTxn(2, 0, 4'hF, 32'h2008, 32'h0, 1, 0, 32'h0BADCAFE, "w3_reread");

        // Randomized traffic against the model, after seeding the words it touches.
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 8; w++) begin
                doTxn(d, 1, 4'hF, 32'(baseOf(d) + 4 * w), 32'h5A000000 | 32'(d * 16 + w),
                      1, 0, 32'h0, $sformatf("seed_d%0d_w%0d", d, w));
            end
        end
        for (int n = 0; n < 60; n++) begin
            randomTxn(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
